// File: rtl/nor_logic_unit.sv
// Bitwise logic unit built only from 2-input NOR gates, with its results queued in a FIFO
// behind a valid/ready handshake. It also counts the results the consumer has taken.
module nor_logic_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_W-1:0]             ops_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);
    localparam logic [WIDTH-1:0] ZERO = '0;

    function automatic logic [WIDTH-1:0] nor2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return ~(x | y);
    endfunction

    logic [WIDTH-1:0] w_not_a, w_not_b, w_nor, w_or, w_and, w_nand, w_xor, w_xnor, w_pass;
    logic [WIDTH-1:0] w_result;
    logic             w_push, w_pop;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_ops_done;

    // Every function is a NOR network; XOR is NOR(NOR(a,b), AND(a,b)).
    assign w_not_a = nor2(a, ZERO);
    assign w_not_b = nor2(b, ZERO);
    assign w_nor   = nor2(a, b);
    assign w_or    = nor2(w_nor, ZERO);
    assign w_and   = nor2(w_not_a, w_not_b);
    assign w_nand  = nor2(w_and, ZERO);
    assign w_xor   = nor2(w_nor, w_and);
    assign w_xnor  = nor2(w_xor, ZERO);
    assign w_pass  = nor2(w_not_a, ZERO);

    always_comb begin
        w_result = ZERO;
        case (op)
            3'b000: w_result = w_not_a;
            3'b001: w_result = w_nor;
            3'b010: w_result = w_or;
            3'b011: w_result = w_and;
            3'b100: w_result = w_nand;
            3'b101: w_result = w_xor;
            3'b110: w_result = w_xnor;
            default: w_result = w_pass;
        endcase
    end

    // Both handshake flags come from registered occupancy only, so out_ready never reaches in_ready.
    assign in_ready  = (r_count < FULL);
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : ZERO;
    assign count     = r_count;
    assign ops_done  = r_ops_done;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ops_done <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + PW'(1);
                r_ops_done <= r_ops_done + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_logic_unit.sv
// Bench for nor_logic_unit: opcode vector table, fill/full, streaming, mid-stream reset and
// counter wrap, all checked against a queue model of the result FIFO.
module tb_nor_logic_unit;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] op;
    logic [7:0] a, b, out_data;
    logic [2:0] count;
    logic [15:0] ops_done;

    logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [7:0] w_a, w_out_data;
    logic [2:0] w_count;
    logic [3:0] w_ops_done;

    nor_logic_unit #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .ops_done(ops_done)
    );

    nor_logic_unit #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(3'b111),
        .a(w_a), .b(8'h00), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .count(w_count), .ops_done(w_ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] q [$];
    int         mops;
    int         n_checks;
    int         n_fail;

    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return ~x;
            3'd1: return ~(x | y);
            3'd2: return x | y;
            3'd3: return x & y;
            3'd4: return ~(x & y);
            3'd5: return x ^ y;
            3'd6: return ~(x ^ y);
            default: return x;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive, compare against the model, advance the model, wait one cycle.
    task automatic cyc(input logic v, input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ordy, input logic [7:0] expv);
        logic push, pop;
        in_valid = v; op = o; a = aa; b = bb; out_ready = ordy;
        #1;
        chk("in_ready",  in_ready,  (q.size() < 4));
        chk("out_valid", out_valid, (q.size() > 0));
        chk("out_data",  out_data,  (q.size() > 0) ? q[0] : 8'h00);
        chk("count",     count,     q.size());
        chk("ops_done",  ops_done,  mops[15:0]);
        pop  = (q.size() > 0) && ordy;
        push = v && (q.size() < 4);
        if (pop) begin
            void'(q.pop_front());
            mops++;
        end
        if (push) q.push_back(expv);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 3'd7; a = 8'hAA; b = 8'h55;
        repeat (n) begin
            @(negedge clk);
            chk("rst_count",     count,     0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data",  out_data,  0);
            chk("rst_ops_done",  ops_done,  0);
        end
        q.delete();
        mops = 0;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] ro;
        logic [7:0] ra, rb;
        n_checks = 0; n_fail = 0; mops = 0;
        vecs[0] = '{3'd0, 8'hC5, 8'h3A, 8'h3A};
        vecs[1] = '{3'd1, 8'hC5, 8'h3A, 8'h00};
        vecs[2] = '{3'd2, 8'hC5, 8'h3A, 8'hFF};
        vecs[3] = '{3'd3, 8'hC5, 8'h3A, 8'h00};
        vecs[4] = '{3'd4, 8'hC5, 8'h3A, 8'hFF};
        vecs[5] = '{3'd5, 8'hC5, 8'h3A, 8'hFF};
        vecs[6] = '{3'd6, 8'hC5, 8'h3A, 8'h00};
        vecs[7] = '{3'd7, 8'hC5, 8'h3A, 8'hC5};
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = 8'h00;

        do_reset(2);

        // Opcode sweep, back-to-back with the consumer always ready
        for (int i = 0; i < 8; i++) cyc(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp);
        cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);
        chk("sweep_ops_done", ops_done, 8);

        // Fill to full with the consumer stalled; the fifth push must be refused
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'(i), 8'h10 + 8'(i), 8'h0F, 1'b0, ref_op(3'(i), 8'h10 + 8'(i), 8'h0F));
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        cyc(1'b1, 3'd5, 8'h77, 8'h11, 1'b1, 8'h00);
        chk("full_pop_count", count, 3);

        // Drain to two, then stream ten cycles of simultaneous push and pop
        cyc(1'b0, 3'd0, 8'hFF, 8'hFF, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7)); ra = 8'($urandom); rb = 8'($urandom);
            cyc(1'b1, ro, ra, rb, 1'b1, ref_op(ro, ra, rb));
        end
        chk("stream_count", count, 2);
        chk("stream_ops_done", ops_done, 8 + 1 + 1 + 10);

        // Mid-stream reset with three entries queued; none of them may reappear
        cyc(1'b1, 3'd3, 8'hF0, 8'h3C, 1'b0, 8'h30);
        chk("pre_rst_count", count, 3);
        do_reset(1);
        cyc(1'b1, 3'd5, 8'h0F, 8'hFF, 1'b1, 8'hF0);
        cyc(1'b1, 3'd1, 8'h01, 8'h02, 1'b1, 8'hFC);
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00);

        // Four-bit counter wrap: 18 edges of push+pop give 17 pops
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("wrap_start", w_ops_done, 0);
        w_in_valid = 1'b1; w_out_ready = 1'b1; w_a = 8'h5A;
        repeat (16) @(negedge clk);
        #1;
        chk("wrap_pre", w_ops_done, 15);
        repeat (2) @(negedge clk);
        #1;
        chk("wrap_post", w_ops_done, 1);
        chk("wrap_data", w_out_data, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
